// File: rtl/w_route_sequencer_pkg.sv
// Shared widths, order-queue entry type and master one-hot codes for the
// W-channel route sequencer.
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_w_pkg;
  localparam int NUM_M  = 3;
  localparam int LEN_W  = `AXI_LEN_BITS;
  localparam int DATA_W = `AXI_DATA_BITS;
  localparam int STRB_W = `AXI_STRB_BITS;

  localparam logic [2:0] M0_OH = 3'b001;
  localparam logic [2:0] M1_OH = 3'b010;
  localparam logic [2:0] M2_OH = 3'b100;

  typedef struct packed {
    logic [2:0]       grant;
    logic [LEN_W-1:0] len;
  } w_order_t;

  // Only a clean one-hot grant may enter the order queue.
  function automatic logic is_onehot3(logic [2:0] g);
    return (g == M0_OH) || (g == M1_OH) || (g == M2_OH);
  endfunction
endpackage

// File: rtl/w_route_sequencer_if.sv
// AW order inputs plus the three master W ports and the slave W port.
// slave = sequencer view, master = environment view.
interface w_route_sequencer_if;
  logic [2:0]                AW_GRANT;
  logic [`AXI_LEN_BITS-1:0]  AW_LEN;
  logic                      AW_HIT;
  logic                      AW_STALL;

  logic [`AXI_DATA_BITS-1:0] WDATA_M0, WDATA_M1, WDATA_M2;
  logic [`AXI_STRB_BITS-1:0] WSTRB_M0, WSTRB_M1, WSTRB_M2;
  logic                      WLAST_M0, WLAST_M1, WLAST_M2;
  logic                      WVALID_M0, WVALID_M1, WVALID_M2;
  logic                      WREADY_M0, WREADY_M1, WREADY_M2;

  logic [`AXI_DATA_BITS-1:0] WDATA_S;
  logic [`AXI_STRB_BITS-1:0] WSTRB_S;
  logic                      WLAST_S;
  logic                      WVALID_S;
  logic                      WREADY_S;
  logic                      LAST_ERR;

  modport slave (
    input  AW_GRANT, AW_LEN, AW_HIT,
    output AW_STALL,
    input  WDATA_M0, WDATA_M1, WDATA_M2, WSTRB_M0, WSTRB_M1, WSTRB_M2,
    input  WLAST_M0, WLAST_M1, WLAST_M2, WVALID_M0, WVALID_M1, WVALID_M2,
    output WREADY_M0, WREADY_M1, WREADY_M2,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S, LAST_ERR,
    input  WREADY_S
  );

  modport master (
    output AW_GRANT, AW_LEN, AW_HIT,
    input  AW_STALL,
    output WDATA_M0, WDATA_M1, WDATA_M2, WSTRB_M0, WSTRB_M1, WSTRB_M2,
    output WLAST_M0, WLAST_M1, WLAST_M2, WVALID_M0, WVALID_M1, WVALID_M2,
    input  WREADY_M0, WREADY_M1, WREADY_M2,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S, LAST_ERR,
    output WREADY_S
  );
endinterface

// File: rtl/w_route_sequencer_order_fifo.sv
// Order queue of {grant, len} entries, one per accepted AW handshake.
module w_order_fifo
  import axi_w_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     push_i,
  input  w_order_t din_i,
  input  logic     pop_i,
  output w_order_t head_o,
  output logic     full_o,
  output logic     empty_o
);
  w_order_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // Full is taken from registered state only: a same-cycle pop does not
  // make room for a push until the next cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Entry storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/w_route_sequencer.sv
// Routes W beats from M0/M1/M2 to the slave in AW grant order, generating
// WLAST from a beat counter and flagging master WLAST disagreements.
module w_route_sequencer
  import axi_w_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rstn,
  w_route_sequencer_if.slave bus
);
  logic [NUM_M-1:0][DATA_W-1:0] wdata_m;
  logic [NUM_M-1:0][STRB_W-1:0] wstrb_m;
  logic [NUM_M-1:0]             wvalid_m, wlast_m, wready_m;

  w_order_t         head, din;
  logic             empty, full, push, pop, hs, wlast_s, wlast_sel;
  logic             wvalid_s;
  logic [DATA_W-1:0] wdata_s;
  logic [STRB_W-1:0] wstrb_s;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;

  assign wdata_m  = {bus.WDATA_M2, bus.WDATA_M1, bus.WDATA_M0};
  assign wstrb_m  = {bus.WSTRB_M2, bus.WSTRB_M1, bus.WSTRB_M0};
  assign wvalid_m = {bus.WVALID_M2, bus.WVALID_M1, bus.WVALID_M0};
  assign wlast_m  = {bus.WLAST_M2, bus.WLAST_M1, bus.WLAST_M0};

  assign din  = {bus.AW_GRANT, bus.AW_LEN};
  assign push = bus.AW_HIT & is_onehot3(bus.AW_GRANT);

  w_order_fifo #(.DEPTH(DEPTH)) u_order (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Lock the slave port onto the head master; everything idles at zero when empty.
  always_comb begin
    wdata_s   = '0;
    wstrb_s   = '0;
    wvalid_s  = 1'b0;
    wlast_sel = 1'b0;
    wready_m  = '0;
    if (!empty) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (head.grant[i]) begin
          wdata_s     = wdata_m[i];
          wstrb_s     = wstrb_m[i];
          wvalid_s    = wvalid_m[i];
          wlast_sel   = wlast_m[i];
          wready_m[i] = bus.WREADY_S;
        end
      end
    end
  end

  assign wlast_s = ~empty & (beat_cnt_q == head.len);
  assign hs      = wvalid_s & bus.WREADY_S;
  assign pop     = hs & wlast_s;

  // Burst boundary comes from the counter only; the master flag is just checked.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (hs) beat_cnt_d = wlast_s ? '0 : beat_cnt_q + LEN_W'(1);
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) beat_cnt_q <= '0;
    else       beat_cnt_q <= beat_cnt_d;
  end

  assign bus.AW_STALL  = full;
  assign bus.WDATA_S   = wdata_s;
  assign bus.WSTRB_S   = wstrb_s;
  assign bus.WVALID_S  = wvalid_s;
  assign bus.WLAST_S   = wlast_s;
  assign bus.LAST_ERR  = hs & (wlast_sel != wlast_s);
  assign bus.WREADY_M0 = wready_m[0];
  assign bus.WREADY_M1 = wready_m[1];
  assign bus.WREADY_M2 = wready_m[2];

  // Upstream must hold AWREADY low while stalled; a hit while full is dropped.
  a_no_hit_when_full: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.AW_HIT && bus.AW_STALL));
endmodule
